// File: rtl/i2c_init_pkg.sv
// i2c_init_pkg: state encoding, end marker and word fields for the I2C init sequencer.
// I2C_INIT_READBACK_EN adds the read-verify states RB_START/RB_WAIT.
package i2c_init_pkg;

  localparam logic [23:0] END_MARKER = 24'hFFFFFF;

  localparam int DEV_MSB = 23;
  localparam int DEV_LSB = 16;
  localparam int REG_MSB = 15;
  localparam int REG_LSB = 8;
  localparam int DAT_MSB = 7;
  localparam int DAT_LSB = 0;

  typedef enum logic [3:0] {
    IDLE,
    PWRUP,
    FETCH,
    LOAD,
    START,
    WAIT_DONE,
    RELEASE,
    GAP,
    FINISH,
    FAIL
`ifdef I2C_INIT_READBACK_EN
    ,
    RB_START,
    RB_WAIT
`endif
  } state_e;

  function automatic logic [7:0] f_dev(input logic [23:0] w);
    return w[DEV_MSB:DEV_LSB];
  endfunction

  function automatic logic [7:0] f_reg(input logic [23:0] w);
    return w[REG_MSB:REG_LSB];
  endfunction

  function automatic logic [7:0] f_dat(input logic [23:0] w);
    return w[DAT_MSB:DAT_LSB];
  endfunction

endpackage

// File: rtl/i2c_init_timer.sv
// i2c_init_timer: loadable down-counter with a zero flag.
// One instance serves the power-up delay, inter-transaction gap and timeout.
module i2c_init_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_init_seq.sv
// i2c_init_seq: walks a ROM table and issues one I2C write per entry with retry.
// Define I2C_INIT_READBACK_EN to read back and verify each written byte.
module i2c_init_seq
  import i2c_init_pkg::*;
#(
  parameter int  NUM_ENTRIES    = 32,
  parameter int  MAX_RETRY      = 3,
  parameter int  PWRUP_CYCLES   = 1000000,
  parameter int  GAP_CYCLES     = 200,
  parameter int  TIMEOUT_CYCLES = 2000000,
  localparam int AW             = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          go,
  output logic [AW-1:0] rom_addr,
  input  logic [23:0]   rom_data,
  output logic          i2c_start,
  output logic          i2c_wr,
  output logic [23:0]   i2c_data,
  input  logic          i2c_busy,
  input  logic          i2c_done,
  input  logic          i2c_error,
  input  logic [7:0]    i2c_rdata,
  output logic          running,
  output logic          init_done,
  output logic          init_error,
  output logic [AW-1:0] fail_index
);

  localparam int TW = 32;
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] PWRUP_LD = TW'(PWRUP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LD    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRY);
  localparam logic [AW:0]   NUM_E    = (AW + 1)'(NUM_ENTRIES);

  state_e          state_q;
  logic [AW:0]     idx_q;
  logic [RW-1:0]   retry_q;
  logic            err_q;
  logic            go_q;
  logic [AW-1:0]   rom_addr_q;
  logic            start_q;
  logic            wr_q;
  logic [23:0]     data_q;
  logic            running_q;
  logic            init_done_q;
  logic            init_error_q;
  logic [AW-1:0]   fail_q;

  logic            go_rise;
  logic            tmr_ld;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;

`ifdef I2C_INIT_READBACK_EN
  logic            rd_q;
`else
  logic            unused_rdata;
  assign unused_rdata = ^i2c_rdata;
`endif

  assign go_rise = go & ~go_q;

  // Reloaded every cycle in the state preceding each timed state.
  always_comb begin
    tmr_ld  = 1'b0;
    tmr_val = '0;
    unique case (state_q)
      IDLE: begin
        tmr_ld  = 1'b1;
        tmr_val = PWRUP_LD;
      end
      LOAD: begin
        tmr_ld  = 1'b1;
        tmr_val = TO_LD;
      end
      RELEASE: begin
        tmr_ld  = 1'b1;
        tmr_val = GAP_LD;
`ifdef I2C_INIT_READBACK_EN
        if (!err_q && !rd_q) tmr_val = TO_LD;
`endif
      end
      default: ;
    endcase
  end

  i2c_init_timer #(
    .W (TW)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (tmr_ld),
    .val_i   (tmr_val),
    .zero_o  (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      retry_q      <= '0;
      err_q        <= 1'b0;
      go_q         <= 1'b1;
      rom_addr_q   <= '0;
      start_q      <= 1'b0;
      wr_q         <= 1'b0;
      data_q       <= '0;
      running_q    <= 1'b0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
      fail_q       <= '0;
`ifdef I2C_INIT_READBACK_EN
      rd_q         <= 1'b0;
`endif
    end else begin
      go_q <= go;
      unique case (state_q)
        IDLE: begin
          if (go_rise) begin
            state_q      <= PWRUP;
            running_q    <= 1'b1;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            fail_q       <= '0;
            idx_q        <= '0;
            retry_q      <= '0;
            rom_addr_q   <= '0;
          end
        end
        PWRUP: begin
          if (tmr_zero) begin
            rom_addr_q <= idx_q[AW-1:0];
            state_q    <= FETCH;
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          data_q <= rom_data;
          if (rom_data == END_MARKER) begin
            state_q <= FINISH;
          end else begin
            state_q <= START;
            start_q <= ~i2c_done;
            wr_q    <= 1'b1;
`ifdef I2C_INIT_READBACK_EN
            rd_q    <= 1'b0;
`endif
          end
        end
        START: begin
          if (i2c_busy) begin
            start_q <= 1'b0;
            state_q <= WAIT_DONE;
          end else if (tmr_zero) begin
            start_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= RELEASE;
          end else begin
            start_q <= ~i2c_done;
          end
        end
        WAIT_DONE: begin
          if (i2c_done) begin
            err_q   <= i2c_error;
            state_q <= RELEASE;
          end else if (tmr_zero) begin
            err_q   <= 1'b1;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (!i2c_done) begin
            if (err_q) begin
              if (retry_q < MAX_R) begin
                retry_q <= retry_q + 1'b1;
                state_q <= GAP;
              end else begin
                state_q <= FAIL;
              end
            end else begin
`ifdef I2C_INIT_READBACK_EN
              if (!rd_q) begin
                rd_q    <= 1'b1;
                wr_q    <= 1'b0;
                start_q <= 1'b1;
                state_q <= RB_START;
              end else
`endif
              begin
                idx_q   <= idx_q + 1'b1;
                retry_q <= '0;
                state_q <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (tmr_zero) begin
            if (idx_q < NUM_E) begin
              rom_addr_q <= idx_q[AW-1:0];
              state_q    <= FETCH;
            end else begin
              state_q <= FINISH;
            end
          end
        end
        FINISH: begin
          init_done_q <= 1'b1;
          running_q   <= 1'b0;
          state_q     <= IDLE;
        end
        FAIL: begin
          init_error_q <= 1'b1;
          fail_q       <= idx_q[AW-1:0];
          running_q    <= 1'b0;
          state_q      <= IDLE;
        end
`ifdef I2C_INIT_READBACK_EN
        RB_START: begin
          if (i2c_busy) begin
            start_q <= 1'b0;
            state_q <= RB_WAIT;
          end else if (tmr_zero) begin
            start_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= RELEASE;
          end else begin
            start_q <= ~i2c_done;
          end
        end
        RB_WAIT: begin
          if (i2c_done) begin
            err_q   <= i2c_error | (i2c_rdata != f_dat(data_q));
            state_q <= RELEASE;
          end else if (tmr_zero) begin
            err_q   <= 1'b1;
            state_q <= RELEASE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign i2c_start  = start_q;
  assign i2c_wr     = wr_q;
  assign i2c_data   = data_q;
  assign running    = running_q;
  assign init_done  = init_done_q;
  assign init_error = init_error_q;
  assign fail_index = fail_q;

endmodule
